// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the up/down counter family.
// Direction encoding and legal parameter ranges.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  localparam longint unsigned MODULUS_MIN = 2;

  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;

  // Largest modulus a WIDTH-bit count can represent.
  function automatic longint unsigned modulus_max(int w);
    return 64'd1 << w;
  endfunction

endpackage

// File: rtl/mod_prescaler.sv
// mod_prescaler: divides enabled cycles by PRESCALE.
// step fires on the last enabled cycle of each window.
module mod_prescaler #(
  parameter int PRESCALE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign step   = enable & w_last;

  // Window position: restarts on clear, frozen while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo up/down counter with
// prescaler, clear/load and wrap-or-saturate at the ends.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MODULUS  = 8,
  parameter bit              SATURATE = 1'b0,
  parameter int              PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam int WP1 = WIDTH + 1;
  localparam logic [WIDTH:0] MAXV = WP1'(MODULUS - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX)
  begin : g_bad_width
    $fatal(1, "mod_updown_counter: WIDTH out of range");
  end

  if (MODULUS < MODULUS_MIN ||
      MODULUS > modulus_max(WIDTH))
  begin : g_bad_mod
    $fatal(1, "mod_updown_counter: MODULUS out of range");
  end

  if (PRESCALE < PRESCALE_MIN ||
      PRESCALE > PRESCALE_MAX)
  begin : g_bad_pre
    $fatal(1, "mod_updown_counter: PRESCALE out of range");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_step;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_nxt;
  logic             w_wrap_nxt;
  logic             w_ld_ok;
  logic             w_unused_msb;

  // Load or clear also restarts the prescaler window.
  if (PRESCALE == 1) begin : g_no_pre
    assign w_step = enable;
  end else begin : g_pre
    mod_prescaler #(
      .PRESCALE(PRESCALE)
    ) u_pre (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .clear (clear | load),
      .step  (w_step)
    );
  end

  assign w_cur        = {1'b0, r_count};
  assign w_ld_ok      = ({1'b0, load_value} <= MAXV);
  assign w_unused_msb = w_nxt[WIDTH];

  // Next count: clear > load > step > hold.
  always_comb begin
    w_nxt      = w_cur;
    w_wrap_nxt = 1'b0;
    if (clear) begin
      w_nxt = '0;
    end else if (load) begin
      w_nxt = w_ld_ok ? {1'b0, load_value} : '0;
    end else if (w_step) begin
      if (up_down == DIR_UP) begin
        if (w_cur == MAXV) begin
          if (!SATURATE) begin
            w_nxt      = '0;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_nxt = w_cur + 1'b1;
        end
      end else begin
        if (w_cur == '0) begin
          if (!SATURATE) begin
            w_nxt      = MAXV;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_nxt = w_cur - 1'b1;
        end
      end
    end
  end

  // Count and wrap pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_nxt[WIDTH-1:0];
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = (up_down == DIR_UP) ? (w_cur == MAXV)
                                     : (w_cur == '0);

endmodule
